demux_1to8_wb: RTL and testbench
================================

Name: demux_1to8_wb

Overview:
- Write-back demultiplexer for the GF(2^233) datapath; the write-side counterpart of the 8:1 operand-select mux.
- Accepts one 233-bit result per handshake with a 3-bit destination index and writes it into one of eight holding registers q0..q7.
- Each holding register has a full flag. The consumer (operand-select side) releases a slot with a per-slot acknowledge.
- Prevents a new result from overwriting an unconsumed operand.

Parameters:
- W, 233, data width of each slot (field element size).
- OVERWRITE, 0, 1 = writes to a full slot are accepted and replace the data; 0 = writes to a full slot are back-pressured.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  input  1  write request valid.
- in_ready  output  1  block can accept the write this cycle.
- in_sel  input  3  destination slot index 0..7.
- in_data  input  W  result value to store.
- rd_ack  input  8  one-hot/multi-hot release pulses; bit k clears full[k].
- full  output  8  bit k = slot k holds unconsumed data.
- q0..q7  output  W each  registered slot contents.

Behaviour:
- Reset (async, rst=1): q0..q7 = 0, full = 8'h00, pipeline stage empty; in_ready = 1 once rst deasserts.
- Transfer occurs on a rising edge with in_valid & in_ready.
- Base latency 1: data is visible on q[in_sel] and full[in_sel]=1 the cycle after the transfer edge.
- in_ready (no pipe) = OVERWRITE | ~full[in_sel] | rd_ack[in_sel]. Combinational from in_sel, full and rd_ack only; never depends on in_valid.
- Release: rd_ack[k] on an edge clears full[k]. q[k] retains its value; data is not zeroed.
- Simultaneous ack and write to the same slot k: the write wins. full[k] stays 1 and q[k] takes the new data.
- Ack and write to different slots: both take effect on the same edge.
- rd_ack on an empty slot: no effect.
- OVERWRITE=1 with a write to a full slot: q[k] is replaced and full[k] stays 1.
- in_valid=0: in_sel and in_data are don't-care; no state changes except acks.
- Only slot in_sel is written; the other seven slots hold.
- in_sel has no invalid encoding; all 8 values map to a slot.
- Reset asserted mid-transfer: the pending write is dropped and all slots are cleared asynchronously.

Optional Feature:
- Macro: DEMUX_WB_PIPE_EN.
- Defined: adds one input register stage (stage_valid, stage_sel, stage_data) between the handshake and the slots.
  - Latency becomes 2 edges from acceptance to q/full update.
  - in_ready = ~stage_valid | stage_drain, where stage_drain = OVERWRITE | ~full[stage_sel] | rd_ack[stage_sel].
  - A staged write that cannot drain holds in the stage until its slot is acked; at most one item is in flight.
  - rst also empties the stage.
- Undefined: single-stage behaviour as above, latency 1.

Test Plan:
- Reset: assert rst mid-simulation with full=8'hFF -> full=8'h00, q0..q7=0 without a clock edge; in_ready=1 after release.
- Write in_sel=3, in_data=233'h1ABC with in_valid=1 -> next cycle q3=233'h1ABC, full=8'h08, all other q unchanged (0).
- Back-pressure (OVERWRITE=0): slot 5 full, write in_sel=5 data 233'h7 -> in_ready=0, q5 unchanged. Then pulse rd_ack=8'h20 in the same cycle -> in_ready=1, q5=233'h7, full[5] stays 1.
- Concurrent: write slot 0 data 233'h55 while rd_ack=8'h02 (slot 1 full) -> q0=233'h55, full[0]=1, full[1]=0, q1 retained.
- Sweep: write slots 0..7 back-to-back with data=index+1 -> full=8'hFF after 8 cycles, qk=k+1; then rd_ack=8'hFF -> full=8'h00.
- With DEMUX_WB_PIPE_EN: write slot 2 data 233'h9 -> q2 updates 2 cycles after acceptance. With slot 2 full and no ack, a second write stalls in the stage and in_ready=0 until rd_ack[2] is pulsed.

Source files
------------

// File: rtl/demux_1to8_wb.sv
// rtl/demux_1to8_wb.sv - 1:8 write-back demultiplexer with per-slot full flags
//
// Purpose:
//   Takes one W-bit result per valid/ready handshake and stores it into one of
//   eight holding registers q0..q7 selected by in_sel. Each slot has a full
//   flag that the consumer clears with a per-slot rd_ack pulse. Unless
//   OVERWRITE is set, a write to a full slot is back-pressured.
//
// Optional feature:
//   DEMUX_WB_PIPE_EN - inserts one input register stage between the handshake
//   and the slots, so an accepted write lands two edges after acceptance.
//
// Parameters:
//   W          slot data width (field element size)
//   OVERWRITE  1 = writes to a full slot replace its data; 0 = back-pressure
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset, clears all state
//   in_valid  write request valid
//   in_ready  write can be accepted this cycle
//   in_sel    destination slot index 0..7
//   in_data   value to store
//   rd_ack    per-slot release pulses, bit k clears full[k]
//   full      bit k = slot k holds unconsumed data
//   q0..q7    registered slot contents

module demux_1to8_wb #(
  parameter int W         = 233,
  parameter int OVERWRITE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_sel,
  input  logic [W-1:0] in_data,
  input  logic [7:0]   rd_ack,
  output logic [7:0]   full,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic [W-1:0] q4,
  output logic [W-1:0] q5,
  output logic [W-1:0] q6,
  output logic [W-1:0] q7
);

  localparam bit OW = (OVERWRITE != 0);

  logic [W-1:0] slot_q [8];

  // Slot write port, fed either straight from the handshake or from the stage
  logic         wr_en;
  logic [2:0]   wr_sel;
  logic [W-1:0] wr_data;

`ifdef DEMUX_WB_PIPE_EN
  logic         stage_valid;
  logic [2:0]   stage_sel;
  logic [W-1:0] stage_data;
  logic         stage_drain;

  // The staged item may move into its slot this edge; an ack on that same
  // slot frees it in time because the write wins over the release.
  assign stage_drain = OW | ~full[stage_sel] | rd_ack[stage_sel];
  assign in_ready    = ~stage_valid | stage_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_sel   <= '0;
      stage_data  <= '0;
    end else if (in_valid && in_ready) begin
      stage_valid <= 1'b1;
      stage_sel   <= in_sel;
      stage_data  <= in_data;
    end else if (stage_drain) begin
      stage_valid <= 1'b0;
    end
  end

  assign wr_en   = stage_valid & stage_drain;
  assign wr_sel  = stage_sel;
  assign wr_data = stage_data;
`else
  // Depends only on the addressed slot state, never on in_valid
  assign in_ready = OW | ~full[in_sel] | rd_ack[in_sel];

  assign wr_en   = in_valid & in_ready;
  assign wr_sel  = in_sel;
  assign wr_data = in_data;
`endif

  // Write takes priority over release on the same slot; q keeps its value on
  // release so the consumer may still read it after acking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (wr_en && (wr_sel == 3'(k))) begin
          slot_q[k] <= wr_data;
          full[k]   <= 1'b1;
        end else if (rd_ack[k]) begin
          full[k]   <= 1'b0;
        end
      end
    end
  end

  assign q0 = slot_q[0];
  assign q1 = slot_q[1];
  assign q2 = slot_q[2];
  assign q3 = slot_q[3];
  assign q4 = slot_q[4];
  assign q5 = slot_q[5];
  assign q6 = slot_q[6];
  assign q7 = slot_q[7];

endmodule

// File: tb/tb_demux_1to8_wb.sv
// tb/tb_demux_1to8_wb.sv - scoreboard testbench for demux_1to8_wb
//
// Purpose:
//   Directed stimulus pushes hand-computed expectations (due cycle, signal,
//   value) into a queue; a monitor on the falling edge pops every item that is
//   due and compares it against the DUT outputs.
//
// Ports: none (top-level bench).

module tb_demux_1to8_wb;

  localparam int W = 233;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [W-1:0] in_data;
  logic [7:0]   rd_ack;
  logic [7:0]   full;
  logic [W-1:0] q_mon [8];

  demux_1to8_wb #(.W(W), .OVERWRITE(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .rd_ack   (rd_ack),
    .full     (full),
    .q0       (q_mon[0]),
    .q1       (q_mon[1]),
    .q2       (q_mon[2]),
    .q3       (q_mon[3]),
    .q4       (q_mon[4]),
    .q5       (q_mon[5]),
    .q6       (q_mon[6]),
    .q7       (q_mon[7])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = in_ready, 1 = full, 2 = q[slot]
  typedef struct {
    int           due;
    int           kind;
    int           slot;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] act_v;

  task automatic push_exp(input int kind, input int slot, input logic [W-1:0] v,
                          input string name, input int dly);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.slot = slot;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_ready(input logic r, input string name, input int dly);
    push_exp(0, 0, W'(r), name, dly);
  endtask

  task automatic chk_full(input logic [7:0] f, input string name, input int dly);
    push_exp(1, 0, W'(f), name, dly);
  endtask

  task automatic chk_q(input int k, input int unsigned v, input string name, input int dly);
    push_exp(2, k, W'(v), name, dly);
  endtask

  task automatic step(input logic v, input int s, input int unsigned d, input logic [7:0] a);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sel   = 3'(s);
    in_data  = W'(d);
    rd_ack   = a;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0:       act_v = W'(in_ready);
          1:       act_v = W'(full);
          default: act_v = q_mon[sb[i].slot];
        endcase
        checks++;
        if (sb[i].due < cyc || act_v !== sb[i].val) begin
          failures++;
          $display("FAIL %s: got %h want %h (due %0d, seen %0d)",
                   sb[i].name, act_v, sb[i].val, sb[i].due, cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sel   = 3'd0;
    in_data  = '0;
    rd_ack   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_ready(1'b1, "reset_ready", 0);
    chk_full(8'h00, "reset_full", 0);
    for (int k = 0; k < 8; k++) chk_q(k, 0, "reset_q", 0);

`ifndef DEMUX_WB_PIPE_EN
    // Basic write to slot 3
    step(1, 3, 32'h1ABC, 8'h00);
    chk_ready(1'b1, "wr3_ready", 0);
    chk_full(8'h08, "wr3_full", 1);
    chk_q(3, 32'h1ABC, "wr3_q3", 1);
    chk_q(0, 0, "wr3_q0", 1);
    chk_q(7, 0, "wr3_q7", 1);

    // Back-pressure on full slot 5, then released by a same-cycle ack
    step(1, 5, 32'h3, 8'h00);
    chk_ready(1'b1, "fill5_ready", 0);
    step(1, 5, 32'h7, 8'h00);
    chk_ready(1'b0, "bp5_ready", 0);
    chk_full(8'h28, "bp5_full", 0);
    step(1, 5, 32'h7, 8'h00);
    chk_ready(1'b0, "bp5_ready_hold", 0);
    chk_q(5, 32'h3, "bp5_q5_held", 0);
    step(1, 5, 32'h7, 8'h20);
    chk_ready(1'b1, "ack5_ready", 0);
    chk_q(5, 32'h7, "ack5_q5", 1);
    chk_full(8'h28, "ack5_full", 1);

    // Write slot 0 while acking slot 1
    step(1, 1, 32'h11, 8'h00);
    chk_ready(1'b1, "fill1_ready", 0);
    step(1, 0, 32'h55, 8'h02);
    chk_full(8'h2A, "conc_full_before", 0);
    chk_ready(1'b1, "conc_ready", 0);
    chk_full(8'h29, "conc_full", 1);
    chk_q(0, 32'h55, "conc_q0", 1);
    chk_q(1, 32'h11, "conc_q1_retained", 1);

    // Ack on empty slot 6 with garbage on the idle write inputs
    step(0, 2, 32'hDEAD, 8'h40);
    chk_full(8'h29, "ack_empty_full", 1);
    chk_q(2, 0, "idle_q2", 1);
    step(0, 0, 0, 8'hFF);
    chk_full(8'h00, "ack_all_full", 1);
    chk_q(5, 32'h7, "ack_all_q5_retained", 1);

    // Back-to-back sweep over all slots
    for (int k = 0; k < 8; k++) begin
      step(1, k, k + 1, 8'h00);
      chk_ready(1'b1, "sweep_ready", 0);
    end
    step(0, 4, 0, 8'h00);
    chk_full(8'hFF, "sweep_full", 0);
    chk_ready(1'b0, "sweep_ready_full", 0);
    for (int k = 0; k < 8; k++) chk_q(k, k + 1, "sweep_q", 0);
    step(0, 0, 0, 8'hFF);
    chk_full(8'h00, "sweep_ack_full", 1);
    chk_q(7, 8, "sweep_ack_q7", 1);

    // Refill, then async reset with a write pending
    for (int k = 0; k < 8; k++) step(1, k, 32'h100 + k, 8'h00);
    step(0, 0, 0, 8'h00);
    chk_full(8'hFF, "refill_full", 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sel   = 3'd2;
    in_data  = W'(32'h99);
    rd_ack   = 8'h04;
    #2;
    rst = 1'b1;
    chk_full(8'h00, "async_rst_full", 0);
    for (int k = 0; k < 8; k++) chk_q(k, 0, "async_rst_q", 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    rd_ack   = 8'h00;
    chk_ready(1'b1, "post_rst_ready", 0);
    chk_full(8'h00, "post_rst_full", 0);
    chk_q(2, 0, "post_rst_q2_dropped", 0);
`else
    // Two-edge latency through the stage
    step(1, 2, 32'h9, 8'h00);
    chk_ready(1'b1, "p_wr2_ready", 0);
    chk_full(8'h00, "p_wr2_full_staged", 1);
    chk_full(8'h04, "p_wr2_full", 2);
    chk_q(2, 32'h9, "p_wr2_q2", 2);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Second write to full slot 2 stalls in the stage
    step(1, 2, 32'hA, 8'h00);
    chk_ready(1'b1, "p_stageA_ready", 0);
    step(1, 2, 32'hB, 8'h00);
    chk_ready(1'b0, "p_stall_ready", 0);
    step(1, 2, 32'hB, 8'h00);
    chk_ready(1'b0, "p_stall_ready_hold", 0);
    chk_q(2, 32'h9, "p_stall_q2", 0);
    step(1, 2, 32'hB, 8'h04);
    chk_ready(1'b1, "p_ack_ready", 0);
    chk_q(2, 32'hA, "p_drainA_q2", 1);
    chk_full(8'h04, "p_drainA_full", 1);
    step(0, 0, 0, 8'h00);
    chk_ready(1'b0, "p_stageB_ready", 0);
    step(0, 0, 0, 8'h04);
    chk_ready(1'b1, "p_ackB_ready", 0);
    chk_q(2, 32'hB, "p_drainB_q2", 1);
    chk_full(8'h04, "p_drainB_full", 1);
    step(0, 0, 0, 8'h00);
    chk_ready(1'b1, "p_empty_ready", 0);

    // Reset with an item stuck in the stage
    step(1, 2, 32'hC, 8'h00);
    step(0, 0, 0, 8'h00);
    #2;
    rst = 1'b1;
    chk_full(8'h00, "p_rst_full", 0);
    chk_q(2, 0, "p_rst_q2", 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_ready(1'b1, "p_post_rst_ready", 0);
    chk_full(8'h00, "p_post_rst_full", 1);
    chk_q(2, 0, "p_post_rst_q2", 1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
